// File: rtl/bist_pkg.sv
// Shared BIST definitions: response-compactor FSM states and MISR defaults.
package bist_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StCompare = 2'd2,
    StDone    = 2'd3
  } bist_state_e;

  localparam int unsigned RESP_W   = 5;
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: Galois-style shift with polynomial
// feedback, then the parallel response XORed into the low bits.
module misr_core
  import bist_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_seed,
  input  logic              shift_en,
  input  logic [RESP_W-1:0] resp_in,
  output logic [SIG_W-1:0]  signature
);

  logic [SIG_W-1:0] sig_q, sig_d;

  // Next signature: shift left, fold in POLY on MSB, then mix in the response.
  always_comb begin
    sig_d = sig_q;
    if (load_seed) begin
      sig_d = SEED;
    end else if (shift_en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
              ^ {{(SIG_W-RESP_W){1'b0}}, resp_in};
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;

endmodule

// File: rtl/response_misr.sv
// Response compactor: captures N qualified datapath responses into a MISR,
// then compares the final signature against an expected value.
module response_misr
  import bist_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter int unsigned      CNT_W = 8,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_in,
  input  logic [SIG_W-1:0]  exp_sig,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  capture_cnt
);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             load_seed, shift_en;

  misr_core #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr_core (
    .clk       (clk),
    .reset     (reset),
    .load_seed (load_seed),
    .shift_en  (shift_en),
    .resp_in   (resp_in),
    .signature (signature)
  );

  // Session FSM: next state, counter, compare result and MISR controls.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    load_seed = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          load_seed = 1'b1;
          n_d       = num_patterns;
          cnt_d     = '0;
          pass_d    = 1'b0;
          state_d   = (num_patterns == '0) ? StCompare : StCapture;
        end
      end
      StCapture: begin
        // Abort wins over a capture presented in the same cycle.
        if (abort) begin
          pass_d  = 1'b0;
          state_d = StIdle;
        end else if (resp_valid) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == n_q - CNT_W'(1)) begin
            state_d = StCompare;
          end
        end
      end
      StCompare: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = StIdle;
        end else begin
          pass_d  = (signature == exp_sig);
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      n_q     <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign busy        = (state_q == StCapture) || (state_q == StCompare);
  assign done        = (state_q == StDone);
  assign pass        = pass_q;
  assign capture_cnt = cnt_q;

endmodule
